// File: rtl/md_unit_if.sv
// Issue/result bundle between the execute stage and md_unit.
// The master side issues ops; the slave side reports busy and HI/LO.
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, src_a, src_b,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, src_a, src_b,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit holding the architectural HI/LO registers.
// Define MD_MADD_EN to enable MADD (md_op 6) and MADDU (md_op 7).
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave md
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MulCnt = 4'(MULT_CYCLES);
  localparam logic [3:0] DivCnt = 4'(DIV_CYCLES);

  state_t      state, stateNxt;
  logic [3:0]  cnt, cntNxt;
  logic [31:0] hiQ, loQ, hiNxt, loNxt;
  logic [31:0] pHi, pLo, pHiNxt, pLoNxt;
  logic        pValid, pValidNxt;

  logic opMul, opDiv, opMthi, opMtlo, opSigned;
`ifdef MD_MADD_EN
  logic opMadd;
`endif

  always_comb begin
    opMul    = 1'b0;
    opDiv    = 1'b0;
    opMthi   = 1'b0;
    opMtlo   = 1'b0;
    opSigned = 1'b0;
`ifdef MD_MADD_EN
    opMadd   = 1'b0;
`endif
    unique case (md.md_op)
      3'd0: begin
        opMul    = 1'b1;
        opSigned = 1'b1;
      end
      3'd1: opMul = 1'b1;
      3'd2: begin
        opDiv    = 1'b1;
        opSigned = 1'b1;
      end
      3'd3: opDiv  = 1'b1;
      3'd4: opMthi = 1'b1;
      3'd5: opMtlo = 1'b1;
      default: begin
`ifdef MD_MADD_EN
        opMadd   = 1'b1;
        opSigned = ~md.md_op[0];
`endif
      end
    endcase
  end

  // Sign-extend to 64 bits so one multiplier serves signed and unsigned.
  logic        negA, negB;
  logic [63:0] mulA, mulB, prod;

  assign negA = opSigned & md.src_a[31];
  assign negB = opSigned & md.src_b[31];
  assign mulA = {{32{negA}}, md.src_a};
  assign mulB = {{32{negB}}, md.src_b};
  assign prod = mulA * mulB;

`ifdef MD_MADD_EN
  logic [63:0] macc;
  assign macc = {hiQ, loQ} + prod;
`endif

  // Magnitude divide: covers 0x80000000 / -1 without overflow.
  logic [31:0] absA, absB, divB;
  logic [31:0] qMag, rMag, quo, rem;

  assign absA = negA ? (32'd0 - md.src_a) : md.src_a;
  assign absB = negB ? (32'd0 - md.src_b) : md.src_b;
  assign divB = (md.src_b == 32'd0) ? 32'd1 : absB;
  assign qMag = absA / divB;
  assign rMag = absA % divB;
  assign quo  = (negA ^ negB) ? (32'd0 - qMag) : qMag;
  assign rem  = negA ? (32'd0 - rMag) : rMag;

  always_comb begin
    stateNxt  = state;
    cntNxt    = cnt;
    hiNxt     = hiQ;
    loNxt     = loQ;
    pHiNxt    = pHi;
    pLoNxt    = pLo;
    pValidNxt = pValid;
    unique case (state)
      IDLE: begin
        if (md.start) begin
          unique case (1'b1)
            opMul: begin
              {pHiNxt, pLoNxt} = prod;
              pValidNxt = 1'b1;
              cntNxt    = MulCnt;
              stateNxt  = RUN;
            end
`ifdef MD_MADD_EN
            opMadd: begin
              {pHiNxt, pLoNxt} = macc;
              pValidNxt = 1'b1;
              cntNxt    = MulCnt;
              stateNxt  = RUN;
            end
`endif
            opDiv: begin
              pHiNxt    = rem;
              pLoNxt    = quo;
              pValidNxt = |md.src_b;
              cntNxt    = DivCnt;
              stateNxt  = RUN;
            end
            opMthi:  hiNxt = md.src_a;
            opMtlo:  loNxt = md.src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cntNxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          if (pValid) begin
            hiNxt = pHi;
            loNxt = pLo;
          end
          pValidNxt = 1'b0;
          stateNxt  = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      hiQ    <= 32'd0;
      loQ    <= 32'd0;
      pHi    <= 32'd0;
      pLo    <= 32'd0;
      pValid <= 1'b0;
    end else begin
      state  <= stateNxt;
      cnt    <= cntNxt;
      hiQ    <= hiNxt;
      loQ    <= loNxt;
      pHi    <= pHiNxt;
      pLo    <= pLoNxt;
      pValid <= pValidNxt;
    end
  end

  assign md.busy = (state == RUN);
  assign md.hi   = hiQ;
  assign md.lo   = loQ;

endmodule
